// File: rtl/msi_bus_arbiter_if.sv
// Bus bundle between msi_bus_arbiter (master modport) and the cache side (slave modport).
// Grants, snoops and data_valid are single-cycle pulses; no ready/backpressure exists on this bus.
interface msi_bus_arbiter_if #(
    parameter int NUM_CPUS  = 2,
    parameter int NUM_LINES = 2
);
    // req_i holds until granted; gnt_o pulses one cycle in GRANT, when msg_i/addr_i of the
    // winner must be valid; flush_i is only legal during the single BCAST cycle.
    logic [NUM_CPUS-1:0]           req_i;
    logic [NUM_CPUS-1:0]           gnt_o;
    logic [3*NUM_CPUS-1:0]         msg_i;
    logic [NUM_LINES*NUM_CPUS-1:0] addr_i;
    logic [3*NUM_CPUS-1:0]         snoop_msg_o;
    logic [NUM_LINES-1:0]          snoop_addr_o;
    logic [NUM_CPUS-1:0]           flush_i;
    logic [NUM_CPUS-1:0]           data_valid_o;
    logic [2:0]                    bus_msg_o;
    logic                          busy_o;
    logic                          err_o;

    modport master (
        input  req_i, msg_i, addr_i, flush_i,
        output gnt_o, snoop_msg_o, snoop_addr_o, data_valid_o, bus_msg_o, busy_o, err_o
    );

    modport slave (
        output req_i, msg_i, addr_i, flush_i,
        input  gnt_o, snoop_msg_o, snoop_addr_o, data_valid_o, bus_msg_o, busy_o, err_o
    );
endinterface

// File: rtl/msi_bus_arbiter.sv
// MSI snooping bus arbiter: grant, broadcast snoop, then complete from a flushing cache or memory.
// Define MSI_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module msi_bus_arbiter #(
    parameter int NUM_CPUS  = 2,
    parameter int NUM_LINES = 2,
    parameter int MEM_LAT   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    msi_bus_arbiter_if.master    bus,
    output logic [2:0]           dbg_state
);
    localparam int IDX_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] MSG_RD   = 3'd1;
    localparam logic [2:0] MSG_RDX  = 3'd2;
    localparam logic [2:0] MSG_UPGR = 3'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        BCAST    = 3'd2,
        MEM_WAIT = 3'd3,
        DATA     = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     win, pick;
    logic [2:0]           cur_msg;
    logic [NUM_LINES-1:0] cur_addr;
    logic [CNT_W-1:0]     cnt;
    logic                 err;
    logic                 err_set;
    logic [NUM_CPUS-1:0]  win_mask;
    logic [NUM_CPUS-1:0]  flush_other;
    logic                 flush_multi;

    assign dbg_state = state;

`ifdef MSI_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (bus.req_i[i]) pick = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] last_winner;

    // Search begins just after the previous winner, which bounds any wait to NUM_CPUS-1 grants.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CPUS; k++) begin
            cand = IDX_W'((int'(last_winner) + k) % NUM_CPUS);
            if (!found && bus.req_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
`endif

    assign win_mask    = NUM_CPUS'(1) << win;
    assign flush_other = bus.flush_i & ~win_mask;
    assign flush_multi = (bus.flush_i & (bus.flush_i - NUM_CPUS'(1))) != '0;

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req_i) state_nxt = GRANT;
            end
            GRANT: state_nxt = BCAST;
            BCAST: begin
                if (cur_msg == MSG_UPGR) begin
                    state_nxt = IDLE;
                end else if (cur_msg == MSG_RD || cur_msg == MSG_RDX) begin
                    state_nxt = (|flush_other) ? DATA : MEM_WAIT;
                end else begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cnt == '0) state_nxt = DATA;
            end
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A flush is only meaningful from a non-winning cache, alone, during the snoop cycle.
        if (state == BCAST) begin
            if (bus.flush_i[win] || flush_multi) err_set = 1'b1;
        end else if (|bus.flush_i) begin
            err_set = 1'b1;
        end
    end

    always_comb begin
        bus.gnt_o        = (state == GRANT) ? win_mask : '0;
        bus.data_valid_o = (state == DATA) ? win_mask : '0;
        bus.busy_o       = (state != IDLE);
        bus.bus_msg_o    = (state == BCAST) ? cur_msg : 3'd0;
        bus.snoop_addr_o = cur_addr;
        bus.err_o        = err;
        bus.snoop_msg_o  = '0;
        for (int j = 0; j < NUM_CPUS; j++) begin
            if (state == BCAST && IDX_W'(j) != win) bus.snoop_msg_o[3*j +: 3] = cur_msg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            win      <= '0;
            cur_msg  <= 3'd0;
            cur_addr <= '0;
            cnt      <= '0;
            err      <= 1'b0;
`ifndef MSI_ARB_FIXED_PRIO_EN
            last_winner <= IDX_W'(NUM_CPUS - 1);
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && (|bus.req_i)) win <= pick;
            if (state == GRANT) begin
                cur_msg  <= bus.msg_i[3*int'(win) +: 3];
                cur_addr <= bus.addr_i[NUM_LINES*int'(win) +: NUM_LINES];
`ifndef MSI_ARB_FIXED_PRIO_EN
                last_winner <= win;
`endif
            end
            if (state == BCAST) cnt <= CNT_LOAD;
            else if (state == MEM_WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (err_set) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter with NUM_CPUS=2, NUM_LINES=2, MEM_LAT=4.
module tb_msi_bus_arbiter;
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_q[$];

    msi_bus_arbiter_if #(.NUM_CPUS(2), .NUM_LINES(2)) bus ();

    msi_bus_arbiter #(.NUM_CPUS(2), .NUM_LINES(2), .MEM_LAT(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] req, input logic [5:0] msg, input logic [3:0] addr);
        bus.req_i  = req;
        bus.msg_i  = msg;
        bus.addr_i = addr;
    endtask

    initial begin
        logic [1:0] dv_acc;
        int         grants;
        rst         = 1'b0;
        bus.req_i   = '0;
        bus.msg_i   = '0;
        bus.addr_i  = '0;
        bus.flush_i = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt_o, 0);
        check("rst_snoop_msg", bus.snoop_msg_o, 0);
        check("rst_snoop_addr", bus.snoop_addr_o, 0);
        check("rst_dv", bus.data_valid_o, 0);
        check("rst_bus_msg", bus.bus_msg_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        step();

        // read miss from cache 0, memory path
        drive(2'b01, 6'b000_001, 4'b00_10);
        step();
        check("rd_gnt", bus.gnt_o, 2'b01);
        bus.req_i = 2'b00;
        step();
        check("rd_snoop_msg", bus.snoop_msg_o, 6'b001_000);
        check("rd_snoop_addr", bus.snoop_addr_o, 2);
        check("rd_bus_msg", bus.bus_msg_o, 1);
        check("rd_gnt_cleared", bus.gnt_o, 0);
        bus.msg_i = '0;
        repeat (4) step();
        check("rd_dv_t6", bus.data_valid_o, 0);
        check("rd_busy_t6", bus.busy_o, 1);
        step();
        check("rd_dv_t7", bus.data_valid_o, 2'b01);
        step();
        check("rd_dv_t8", bus.data_valid_o, 0);
        check("rd_busy_t8", bus.busy_o, 0);
        check("rd_snoop_addr_hold", bus.snoop_addr_o, 2);

        // cache-to-cache RdX from cache 1, cache 0 flushes
        drive(2'b10, 6'b010_000, 4'b11_00);
        step();
        check("c2c_gnt", bus.gnt_o, 2'b10);
        bus.req_i = 2'b00;
        step();
        check("c2c_snoop_msg", bus.snoop_msg_o, 6'b000_010);
        check("c2c_snoop_addr", bus.snoop_addr_o, 3);
        bus.flush_i = 2'b01;
        step();
        bus.flush_i = 2'b00;
        check("c2c_dv_t3", bus.data_valid_o, 2'b10);
        step();
        check("c2c_busy_t4", bus.busy_o, 0);
        check("c2c_err", bus.err_o, 0);

        // upgrade from cache 0
        drive(2'b01, 6'b000_011, 4'b00_01);
        step();
        dv_acc = bus.data_valid_o;
        check("upg_gnt", bus.gnt_o, 2'b01);
        bus.req_i = 2'b00;
        step();
        dv_acc |= bus.data_valid_o;
        check("upg_snoop_msg", bus.snoop_msg_o, 6'b011_000);
        check("upg_bus_msg", bus.bus_msg_o, 3);
        step();
        dv_acc |= bus.data_valid_o;
        check("upg_busy_t3", bus.busy_o, 0);
        step();
        dv_acc |= bus.data_valid_o;
        check("upg_no_dv", dv_acc, 0);
        check("upg_err", bus.err_o, 0);

        // contention: both caches request continuously
        do_reset();
`ifdef MSI_ARB_FIXED_PRIO_EN
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        drive(2'b11, 6'b011_011, 4'b01_10);
        grants = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            step();
            if (bus.gnt_o != '0) begin
                check($sformatf("cont_gnt%0d", grants), bus.gnt_o, exp_q.pop_front());
                grants++;
                if (grants == 4) bus.req_i = 2'b00;
            end
        end
        if (grants < 4) check("cont_timeout", grants, 4);
        bus.req_i = 2'b00;
        repeat (4) step();
        check("cont_idle", bus.busy_o, 0);

        // bad message from winner
        do_reset();
        drive(2'b01, 6'b000_000, 4'b00_00);
        step();
        bus.req_i = 2'b00;
        step();
        check("badmsg_err_t2", bus.err_o, 0);
        step();
        check("badmsg_err_t3", bus.err_o, 1);
        check("badmsg_busy_t3", bus.busy_o, 0);
        do_reset();
        check("err_cleared", bus.err_o, 0);

        // winner flushes its own snoop
        drive(2'b10, 6'b001_000, 4'b00_00);
        step();
        bus.req_i = 2'b00;
        step();
        bus.flush_i = 2'b10;
        step();
        bus.flush_i = 2'b00;
        check("wflush_err", bus.err_o, 1);
        check("wflush_mem_wait", dbg_state, 3);
        repeat (6) step();
        check("wflush_idle", bus.busy_o, 0);
        check("wflush_err_sticky", bus.err_o, 1);

        // asynchronous reset during MEM_WAIT
        drive(2'b01, 6'b000_001, 4'b00_10);
        step();
        bus.req_i = 2'b00;
        repeat (3) step();
        check("mw_state", dbg_state, 3);
        #2 rst = 1'b0;
        #1;
        check("arst_state", dbg_state, 0);
        check("arst_busy", bus.busy_o, 0);
        check("arst_err", bus.err_o, 0);
        check("arst_snoop_addr", bus.snoop_addr_o, 0);
        check("arst_outs", {bus.gnt_o, bus.data_valid_o, bus.bus_msg_o, bus.snoop_msg_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        dv_acc = '0;
        repeat (10) begin
            step();
            dv_acc |= bus.data_valid_o;
        end
        check("arst_no_dv", dv_acc, 0);
        check("arst_idle", bus.busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/msi_bus_arbiter.md
# msi_bus_arbiter

Shared-bus arbiter and responder for the MSI snooping system. It grants the bus to one cache controller at a time and captures that cache's bus message and address. It broadcasts the message to every other cache as a snoop, then completes the transaction with a data-valid pulse. Data comes either from a flushing cache (cache-to-cache) or from a fixed-latency memory model. It sits between the N cache controllers and memory: it receives their bus requests and returns their grants.

## Interface
Parameters:
- NUM_CPUS, 2: number of cache controllers on the bus (>=2).
- NUM_LINES, 2: address width in bits; matches the cache address port width.
- MEM_LAT, 4: memory response latency in cycles (>=1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  NUM_CPUS  per-cache bus request (cache pr_bus_req_o).
- gnt_o  output  NUM_CPUS  one-hot grant pulse (cache pr_bus_req_i).
- msg_i  input  3*NUM_CPUS  per-cache bus message; slot i is bits [3i+2:3i]. Encoding: 0 Idle, 1 Rd, 2 RdX, 3 Upgr.
- addr_i  input  NUM_LINES*NUM_CPUS  per-cache line address, slot i.
- snoop_msg_o  output  3*NUM_CPUS  per-cache snooped message (cache bus_msg_i).
- snoop_addr_o  output  NUM_LINES  broadcast address (cache addr_i).
- flush_i  input  NUM_CPUS  per-cache flush (cache flush_o).
- data_valid_o  output  NUM_CPUS  one-cycle completion pulse to the requester (cache data_valid_i).
- bus_msg_o  output  3  current bus transaction, for memory/monitor.
- busy_o  output  1  high in every non-IDLE state.
- err_o  output  1  sticky protocol-error flag.

## Operation
FSM states: IDLE, GRANT, BCAST, MEM_WAIT, DATA.
- IDLE:
  - If req_i != 0, select a winner w, register gnt_o = 1<<w, and go to GRANT.
  - Default policy is round-robin: the search starts at (last_winner+1) mod NUM_CPUS.
- GRANT:
  - gnt_o is high for exactly this cycle.
  - At the end of the cycle, capture msg_i[w] and addr_i[w] into cur_msg and cur_addr; clear gnt_o; go to BCAST.
  - req_i is ignored outside IDLE.
- BCAST (exactly one cycle):
  - bus_msg_o = cur_msg; snoop_addr_o = cur_addr.
  - snoop_msg_o slot j = cur_msg for every j != w; slot w = 0 (Idle).
  - flush_i is sampled in this cycle.
- Exits from BCAST:
  - cur_msg Upgr: go to IDLE; no data_valid.
  - cur_msg Rd or RdX with flush_i[j] for some j != w: go to DATA.
  - cur_msg Rd or RdX otherwise: load counter with MEM_LAT-1 and go to MEM_WAIT.
  - cur_msg Idle or >3: set err_o, go to IDLE.
- MEM_WAIT: decrement the counter each cycle; at 0 go to DATA.
- DATA: data_valid_o = 1<<w for one cycle; go to IDLE.
- Outside BCAST: snoop_msg_o = 0, bus_msg_o = 0, snoop_addr_o holds its last value.
- err_o is also set by any of:
  - flush_i[w] in BCAST;
  - more than one flush_i bit in BCAST;
  - flush_i asserted in any non-BCAST state.
- err_o clears only on reset.
- last_winner updates in GRANT.

## Timing
- Reset values:
  - gnt_o = 0, snoop_msg_o = 0, snoop_addr_o = 0, data_valid_o = 0, bus_msg_o = 0, busy_o = 0, err_o = 0.
  - State IDLE; last_winner = NUM_CPUS-1, so cache 0 has first priority.
  - Reset asserted mid-transaction aborts immediately, with no data_valid pulse.
- With req_i seen in IDLE at cycle t:
  - gnt_o is high in cycle t+1 and the snoop is broadcast in cycle t+2.
  - Upgr: IDLE at t+3.
  - Flush: data_valid_o at t+3.
  - Memory: data_valid_o at t+3+MEM_LAT.
- Back-to-back: a new request can be granted in the IDLE cycle after DATA or Upgr. The minimum turnaround is 1 idle cycle.
- Simultaneous requests: exactly one gnt_o bit per grant, and no cache is starved. Round-robin bounds the wait to NUM_CPUS-1 transactions.
- Requests held continuously by all caches: grants rotate 0,1,...,NUM_CPUS-1,0.

## Configuration
- MSI_ARB_FIXED_PRIO_EN defined: fixed priority, the lowest-index requester always wins, and last_winner is unused.
- Undefined (default): round-robin as described above.

## Test plan
- Single read miss, memory path (MEM_LAT=4): cache 0 requests with msg_i slot0 = 1, addr 2.
  - gnt_o=01 in t+1.
  - In t+2: snoop_msg_o slot1 = 1, slot0 = 0, snoop_addr_o = 2.
  - data_valid_o=01 at t+7.
- Cache-to-cache: cache 1 issues RdX (2) and cache 0 asserts flush_i=01 in BCAST.
  - data_valid_o=10 at t+3.
  - No MEM_WAIT cycles; busy_o low at t+4.
- Upgrade: cache 0 issues msg 3.
  - Snoop is broadcast in t+2; IDLE at t+3.
  - data_valid_o never asserts; err_o stays 0.
- Contention: req_i=11 held for 4 transactions. Grants go 01,10,01,10 (default build); 01,01,01,01 with MSI_ARB_FIXED_PRIO_EN.
- Errors: winner sends msg 0, giving err_o=1 at t+3. Separately, a winner flush in BCAST also sets err_o, and err_o stays 1 until reset.
- Reset mid-MEM_WAIT: drop rst_i asynchronously.
  - All outputs go to 0 immediately and the state returns to IDLE.
  - No data_valid_o pulse after rst_i is released.
